// File: rtl/conv_sched_if.sv
// Window-fetch, core and result-stream signals between conv_sched and its environment.
// master = sequencer side, slave = window buffer / core / consumer side.
interface conv_sched_if #(
  parameter int COORD_W = 5,
  parameter int ADDR_W  = 10
);
  logic               win_req;
  logic [COORD_W-1:0] win_row;
  logic [COORD_W-1:0] win_col;
  logic               win_ack;
  logic               core_en;
  logic               core_valid;
  logic [38:0]        core_out;
  logic               res_valid;
  logic               res_ready;
  logic [15:0]        res_data;
  logic [ADDR_W-1:0]  res_addr;

  modport master (
    output win_req, win_row, win_col, core_en, res_valid, res_data, res_addr,
    input  win_ack, core_valid, core_out, res_ready
  );

  modport slave (
    input  win_req, win_row, win_col, core_en, res_valid, res_data, res_addr,
    output win_ack, core_valid, core_out, res_ready
  );
endinterface

// File: rtl/conv_sched.sv
// Frame sequencer for the 7x7 convolution core: window scan, core firing, Q8.8
// re-quantisation and a credit-protected result FIFO.
module conv_sched #(
  parameter int OUT_W      = 22,
  parameter int OUT_H      = 22,
  parameter int COORD_W    = 5,
  parameter int ADDR_W     = 10,
  parameter int LAT        = 7,
  parameter int FIFO_DEPTH = 8,
  parameter int SHIFT      = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         cfg_relu_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         lat_err_o,
  conv_sched_if.master bus
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  // Pipeline occupancy is bounded by the credit limit and by the core latency.
  localparam int OCC_MAX = (FIFO_DEPTH > LAT) ? FIFO_DEPTH : LAT;
  localparam int CNT_W   = $clog2(OCC_MAX + 1);
  localparam logic signed [39:0] RND = 40'sd1 <<< (SHIFT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
  logic [CNT_W-1:0]   infl_q, infl_d, cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W-1:0]  pop_q, pop_d;
  logic               relu_q, relu_d, lat_err_q, lat_err_d;
  logic [15:0]        mem_q [FIFO_DEPTH];

  logic               credit, push, pop, last_pos, start_ok;
  logic [CNT_W:0]     occ;
  logic signed [39:0] rq_sum, rq_shift;
  logic [15:0]        rq_res;

  always_comb begin
    rq_sum   = {bus.core_out[38], bus.core_out} + RND;
    rq_shift = rq_sum >>> SHIFT;
    if (relu_q && rq_shift < 40'sd0)   rq_res = '0;
    else if (rq_shift > 40'sd32767)    rq_res = 16'h7FFF;
    else if (rq_shift < -40'sd32768)   rq_res = 16'h8000;
    else                               rq_res = rq_shift[15:0];
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    relu_d      = relu_q;
    start_ok    = 1'b0;
    bus.win_req = 1'b0;
    bus.core_en = 1'b0;
    done_o      = 1'b0;
    occ         = {1'b0, infl_q} + {1'b0, cnt_q};
    credit      = occ < (CNT_W + 1)'(FIFO_DEPTH);
    last_pos    = (row_q == COORD_W'(OUT_H - 1)) && (col_q == COORD_W'(OUT_W - 1));

    case (state_q)
      IDLE: begin
        if (start_i) begin
          start_ok = 1'b1;
          row_d    = '0;
          col_d    = '0;
          relu_d   = cfg_relu_i;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        bus.win_req = credit;
        if (credit && bus.win_ack) state_d = ISSUE;
      end
      ISSUE: begin
        bus.core_en = 1'b1;
        if (last_pos) begin
          state_d = DRAIN;
        end else begin
          state_d = FETCH;
          if (col_q == COORD_W'(OUT_W - 1)) begin
            col_d = '0;
            row_d = row_q + COORD_W'(1);
          end else begin
            col_d = col_q + COORD_W'(1);
          end
        end
      end
      DRAIN: begin
        if (infl_q == '0 && cnt_q == '0) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_o = (state_q != IDLE) && !done_o;

    // Results with nothing in flight (stale after reset, or spurious) are dropped.
    push = bus.core_valid && (infl_q != '0);
    pop  = bus.res_valid && bus.res_ready;

    infl_d = infl_q;
    if (bus.core_en && !push)      infl_d = infl_q + CNT_W'(1);
    else if (!bus.core_en && push) infl_d = infl_q - CNT_W'(1);

    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);

    pop_d     = pop ? pop_q + ADDR_W'(1) : pop_q;
    lat_err_d = lat_err_q | (bus.core_valid && infl_q == '0);

    if (start_ok) begin
      infl_d    = '0;
      pop_d     = '0;
      lat_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      infl_q    <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pop_q     <= '0;
      relu_q    <= 1'b0;
      lat_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      infl_q    <= infl_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_q + PTR_W'(push);
      rd_ptr_q  <= rd_ptr_q + PTR_W'(pop);
      pop_q     <= pop_d;
      relu_q    <= relu_d;
      lat_err_q <= lat_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rq_res;
  end

  assign bus.win_row   = row_q;
  assign bus.win_col   = col_q;
  assign bus.res_valid = (cnt_q != '0);
  assign bus.res_data  = bus.res_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign bus.res_addr  = pop_q;
  assign lat_err_o     = lat_err_q;
endmodule

// File: tb/tb_conv_sched.sv
// Randomised scoreboard bench for conv_sched: core model, window-order model and
// arithmetic re-quantisation reference.
module tb_conv_sched;
  localparam int OUT_W = 22, OUT_H = 22, COORD_W = 5, ADDR_W = 10;
  localparam int LAT = 7, FIFO_DEPTH = 8, SHIFT = 8;
  localparam int NPOS = OUT_W * OUT_H;

  logic clk = 1'b0, rst = 1'b0, start_i = 1'b0, cfg_relu_i = 1'b0;
  logic busy_o, done_o, lat_err_o;

  conv_sched_if #(.COORD_W(COORD_W), .ADDR_W(ADDR_W)) bus ();

  conv_sched #(.OUT_W(OUT_W), .OUT_H(OUT_H), .COORD_W(COORD_W), .ADDR_W(ADDR_W),
               .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cfg_relu_i(cfg_relu_i),
    .busy_o(busy_o), .done_o(done_o), .lat_err_o(lat_err_o), .bus(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct { longint due; logic [38:0] val; } pipe_t;
  typedef struct { int addr; logic [15:0] data; } exp_t;

  int     n_cmp = 0, n_bad = 0;
  longint cyc = 0;
  int     ack_mode = 0, rdy_mode = 0;
  bit     spur = 0, cur_relu = 0;
  int     issue_idx = 0, ack_idx = 0, frame_pops = 0, done_cnt = 0, en_cnt = 0;
  pipe_t  pipe[$];
  exp_t   expq[$];
  bit     prev_req = 0, prev_ack = 0, prev_pop = 0;
  logic [COORD_W-1:0] prev_row = '0, prev_col = '0;
  longint cm_v, cm_r;
  logic [15:0] cm_e;
  exp_t   mon_e;

  longint      tbl_v [9] = '{64'sd384, -64'sd384, 64'sd1073741824, -64'sd1073741824,
                             64'sd127, 64'sd128, -64'sd129, 64'sd8388479, -64'sd8388736};
  logic [15:0] tbl_e [9] = '{16'h0002, 16'hFFFF, 16'h7FFF, 16'h8000,
                             16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round-half-up division by 2^SHIFT, then clamp to int16, then optional ReLU.
  function automatic logic [15:0] ref_q(input longint v, input bit relu);
    longint n, q;
    n = v + (64'sd1 <<< (SHIFT - 1));
    q = n / (64'sd1 <<< SHIFT);
    if ((n % (64'sd1 <<< SHIFT)) != 0 && n < 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    if (relu && q < 0) q = 0;
    return 16'(q);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Environment drivers: core pipeline, window ack and consumer ready.
  always @(posedge clk) begin
    #1;
    bus.core_valid = 1'b0;
    bus.core_out   = '0;
    if (spur) begin
      bus.core_valid = 1'b1;
      bus.core_out   = 39'd1000;
    end else if (pipe.size() > 0 && pipe[0].due == cyc) begin
      bus.core_valid = 1'b1;
      bus.core_out   = pipe[0].val;
      void'(pipe.pop_front());
    end
    bus.win_ack   = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
    bus.res_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
  end

  // Core model and issue-side protocol: schedules results and pushes expectations.
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 0;
      prev_ack = 0;
    end else begin
      chk("core_en_after_ack", bus.core_en, prev_req && prev_ack);
      if (prev_req && !prev_ack) begin
        chk("req_hold", bus.win_req, 1);
        chk("row_hold", bus.win_row, prev_row);
        chk("col_hold", bus.win_col, prev_col);
      end
      if (bus.core_en) begin
        if (issue_idx < 9) begin
          cm_v = tbl_v[issue_idx];
          cm_e = (cur_relu && tbl_e[issue_idx][15]) ? 16'h0000 : tbl_e[issue_idx];
        end else begin
          if ($urandom_range(0, 1) == 0) begin
            cm_v = longint'($urandom_range(0, 4000000)) - 64'sd2000000;
          end else begin
            cm_r = longint'({$urandom, $urandom});
            cm_v = (cm_r <<< 25) >>> 25;
          end
          cm_e = ref_q(cm_v, cur_relu);
        end
        pipe.push_back('{cyc + LAT, 39'(cm_v)});
        expq.push_back('{issue_idx, cm_e});
        issue_idx++;
        en_cnt++;
      end
      if (bus.win_req && bus.win_ack) begin
        chk("win_row", bus.win_row, ack_idx / OUT_W);
        chk("win_col", bus.win_col, ack_idx % OUT_W);
        ack_idx++;
      end
      prev_req = bus.win_req;
      prev_ack = bus.win_ack;
      prev_row = bus.win_row;
      prev_col = bus.win_col;
    end
  end

  // Result monitor: pops the scoreboard on every accepted result.
  always @(negedge clk) begin
    if (rst) begin
      prev_pop = 0;
    end else begin
      if (done_o) begin
        done_cnt++;
        chk("busy_at_done", busy_o, 0);
        chk("pops_at_done", frame_pops, NPOS);
        chk("pop_before_done", prev_pop, 1);
      end
      prev_pop = bus.res_valid && bus.res_ready;
      if (prev_pop) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: addr %0d data %0h with empty scoreboard",
                   bus.res_addr, bus.res_data);
        end else begin
          mon_e = expq.pop_front();
          chk("res_addr", bus.res_addr, mon_e.addr);
          chk("res_data", bus.res_data, mon_e.data);
          frame_pops++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic chk_reset_outs();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_win_req", bus.win_req, 0);
    chk("rst_core_en", bus.core_en, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_lat_err", lat_err_o, 0);
    chk("rst_win_row", bus.win_row, 0);
    chk("rst_win_col", bus.win_col, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_addr", bus.res_addr, 0);
  endtask

  task automatic start_frame(input bit relu);
    issue_idx = 0; ack_idx = 0; frame_pops = 0; done_cnt = 0; en_cnt = 0;
    cur_relu = relu;
    @(posedge clk); #1;
    start_i = 1'b1;
    cfg_relu_i = relu;
    tick();
    chk("busy_cycle0", busy_o, 0);
    @(posedge clk); #1;
    start_i = 1'b0;
    cfg_relu_i = ~relu;
    tick();
    chk("busy_cycle1", busy_o, 1);
    chk("lat_err_cleared", lat_err_o, 0);
    chk("req_cycle1", bus.win_req, 1);
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while (done_cnt == 0 && k < limit) begin
      tick();
      k++;
    end
    chk("done_seen", done_cnt, 1);
    repeat (3) tick();
    chk("done_once", done_cnt, 1);
    chk("busy_after_done", busy_o, 0);
    chk("scoreboard_empty", expq.size(), 0);
    chk("lat_err_clean", lat_err_o, 0);
  endtask

  initial begin
    bus.win_ack = 1'b0; bus.core_valid = 1'b0; bus.core_out = '0; bus.res_ready = 1'b0;
    #2 rst = 1'b1;
    repeat (3) tick();
    chk_reset_outs();
    rst = 1'b0;
    tick();

    // Full-rate frame: same-cycle acks, consumer always ready.
    ack_mode = 0; rdy_mode = 0;
    start_frame(1'b0);
    wait_done(5000);

    // ReLU frame with random acks and random backpressure.
    ack_mode = 1; rdy_mode = 1;
    start_frame(1'b1);
    wait_done(20000);

    // Consumer stalled: issue must stop at the FIFO depth.
    ack_mode = 0; rdy_mode = 2;
    start_frame(1'b0);
    repeat (100) tick();
    chk("bp_core_en_count", en_cnt, FIFO_DEPTH);
    chk("bp_win_req_low", bus.win_req, 0);
    chk("bp_res_valid", bus.res_valid, 1);
    rdy_mode = 0;
    wait_done(5000);

    // Delayed acknowledge.
    ack_mode = 2; rdy_mode = 1;
    start_frame(1'b0);
    repeat (5) tick();
    chk("dly_no_core_en", en_cnt, 0);
    chk("dly_req_high", bus.win_req, 1);
    chk("dly_row", bus.win_row, 0);
    chk("dly_col", bus.win_col, 0);
    ack_mode = 0;
    repeat (2) tick();
    chk("dly_one_core_en", en_cnt, 1);
    ack_mode = 1;
    wait_done(20000);

    // Spurious core_valid while idle.
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    chk("spur_lat_err", lat_err_o, 1);
    chk("spur_no_push", bus.res_valid, 0);
    ack_mode = 1; rdy_mode = 0;
    start_frame(1'b0);
    wait_done(20000);

    // Reset with three results in flight.
    ack_mode = 0; rdy_mode = 0;
    start_frame(1'b0);
    for (int k = 0; k < 200; k++) begin
      if (pipe.size() == 3 && !bus.core_en) break;
      tick();
    end
    chk("inflight_three", pipe.size(), 3);
    rst = 1'b1;
    #1;
    chk_reset_outs();
    expq.delete();
    repeat (2) tick();
    rst = 1'b0;
    repeat (12) tick();
    chk("late_valid_lat_err", lat_err_o, 1);
    chk("late_valid_no_push", bus.res_valid, 0);
    chk("core_pipe_drained", pipe.size(), 0);
    ack_mode = 1; rdy_mode = 1;
    start_frame(1'b1);
    wait_done(20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_sched.md
# conv_sched

Frame-level sequencer for the 7x7 convolution core (49 parallel multipliers, fixed 7-cycle enable-to-valid latency, no stall input). It scans every output position of one feature map and fetches each 7x7 window from the window buffer. It fires the core once per window, then re-quantises the 39-bit core results to 16-bit Q8.8. Results drain through an 8-entry output FIFO with ready/valid backpressure, and a credit scheme keeps the non-stallable core pipeline from overrunning the FIFO.

## Interface
- OUT_W, 22: output positions per row (28-pixel input minus 7, plus 1)
- OUT_H, 22: output rows
- COORD_W, 5: width of window row/column coordinates
- ADDR_W, 10: width of result address
- LAT, 7: core enable-to-valid latency, used only for documentation and checking
- FIFO_DEPTH, 8: output FIFO entries (power of two)
- SHIFT, 8: fraction bits dropped during re-quantisation (core output is Q.16; result is Q8.8)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle, ignored while busy
- cfg_relu  in  1  sampled on an accepted start; 1 clamps negative results to 0
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final result is popped
- win_req  out  1  request for the window at (win_row, win_col)
- win_row, win_col  out  COORD_W  top-left coordinate of the requested window
- win_ack  in  1  window and weights on the core inputs are valid; may assert in the same cycle as win_req
- core_en  out  1  one-cycle enable to the core
- core_valid  in  1  core result strobe
- core_out  in  39  signed core sum
- res_valid  out  1  FIFO not empty
- res_ready  in  1  consumer accepts
- res_data  out  16  signed Q8.8 result
- res_addr  out  ADDR_W  raster index row*OUT_W+col of the result at the FIFO head
- lat_err  out  1  sticky; set when core_valid arrives with zero results in flight; cleared by rst or an accepted start

## Operation
- States are IDLE, FETCH, ISSUE and DRAIN.
- IDLE:
  - On start, clear row, col, inflight, pop count and lat_err, latch cfg_relu, then go to FETCH.
- FETCH:
  - Assert win_req only when inflight + fifo_count < FIFO_DEPTH (credit available). Otherwise hold win_req low and stay in FETCH.
  - Hold win_row and win_col constant until the ack.
  - On win_req & win_ack, go to ISSUE.
- ISSUE:
  - core_en = 1 for exactly one cycle, and inflight increments.
  - Advance col. When col reaches OUT_W-1, col wraps to 0 and row increments.
  - After position (OUT_H-1, OUT_W-1), go to DRAIN; otherwise go to FETCH.
- DRAIN:
  - Wait until inflight == 0 and the FIFO is empty with the last pop complete.
  - Then pulse done and return to IDLE.
- inflight counter:
  - +1 on core_en, -1 on core_valid.
  - Both in the same cycle leave it unchanged.
  - core_valid with inflight == 0 sets lat_err and the counter stays 0.
- Re-quantisation, applied to core_out on core_valid and pushed into the FIFO:
  - t = (core_out + 2^(SHIFT-1)) >>> SHIFT, an arithmetic shift with 40-bit intermediate.
  - Saturate t to [-32768, 32767].
  - If cfg_relu is set and t < 0, the result is 0.
- FIFO and addresses:
  - A push never finds the FIFO full; the credit rule guarantees this.
  - Results arrive in issue order. res_addr equals the pop counter, which increments on res_valid & res_ready.
  - Simultaneous push and pop keeps fifo_count unchanged.
- rst in any state:
  - Returns to IDLE and flushes the FIFO.
  - In-flight core results arriving after reset are discarded: inflight is 0 and lat_err is set.

## Timing
- Reset values: busy, done, win_req, core_en, res_valid and lat_err are 0; win_row, win_col, res_data and res_addr are 0.
- start in cycle 0, accepted: busy = 1 and the state is FETCH from cycle 1. win_req is high in cycle 1 if credit is available.
- Ack in cycle n: core_en is high in cycle n+1, and the next win_req can be high in cycle n+2. Peak throughput is one window per 2 cycles.
- The core returns core_valid at core_en + LAT. The result is visible at res_data / res_valid in the cycle after core_valid (registered FIFO write).
- done pulses one cycle after the final pop handshake. busy falls in the same cycle as done.
- start coinciding with done is ignored. A new start is accepted from the cycle after done.

## Test plan
- Basic frame, OUT_W=2, OUT_H=2, res_ready held at 1, ack on the same cycle as req:
  - Expect windows (0,0),(0,1),(1,0),(1,1) in order, with 4 core_en pulses spaced 2 cycles apart.
  - Expect res_addr values 0,1,2,3.
  - Expect done exactly once, with busy low afterwards.
- Re-quantisation, with SHIFT=8 and cfg_relu=0:
  - core_out = 384 -> 0x0002.
  - core_out = -384 -> 0xFFFF.
  - core_out = 2^30 -> 0x7FFF.
  - core_out = -2^30 -> 0x8000.
  - With cfg_relu=1, core_out = -384 -> 0x0000.
- Backpressure, default size, res_ready held at 0:
  - Exactly 8 core_en pulses, then win_req stays low and no FIFO overflow occurs.
  - Releasing res_ready resumes issue. All 484 results arrive with addresses 0..483 contiguous.
- Delayed ack: hold win_ack low for 5 cycles.
  - win_req and coordinates stay stable, no core_en fires, and exactly one core_en follows the ack.
- Spurious core_valid while idle sets lat_err. An accepted start clears lat_err.
- Reset mid-frame, with rst asserted while 3 results are in flight:
  - All outputs return to their reset values immediately.
  - Late core_valid pulses set lat_err and push nothing.
  - A subsequent start runs a clean full frame.
